// File: rtl/add_serial.sv
// Bit-serial 4-bit adder: IDLE/RUN/DONE FSM adds one bit per clock,
// LSB first, and holds an 8-bit result that is gated by the enable.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   en    - block enable; qualifies start, gates out, aborts RUN when low
//   start - one-cycle request to begin an addition (IDLE only)
//   a, b  - 4-bit operands, captured on an accepted start
//   out   - 8-bit result register AND {8{en}}
//   busy  - high while in RUN
//   done  - one-cycle pulse while in DONE (result just loaded)
//
// Build option: define ADD_SERIAL_SIGNED_EN to treat a and b as two's
// complement and sign-extend the 5-bit sum; otherwise the sum is unsigned
// and zero-extended.
module add_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        c_q, c_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  sum_q, sum_d;
    logic [7:0]  res_q, res_d;

    logic        s_bit;
    logic        c_nxt;
    logic        bit4;
    logic [2:0]  upper;

    // Full adder on the current LSBs of the operand shift registers.
    assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

`ifdef ADD_SERIAL_SIGNED_EN
    // On the last bit a_q[0]/b_q[0] are the operand sign bits, so this
    // is bit 4 of the sign-extended 5-bit sum.
    assign bit4  = a_q[0] ^ b_q[0] ^ c_nxt;
    assign upper = {3{bit4}};
`else
    assign bit4  = c_nxt;
    assign upper = 3'b000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            c_q     <= 1'b0;
            cnt_q   <= 2'd0;
            sum_q   <= 4'd0;
            res_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start && en) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    // Abort: result register is left untouched.
                    state_d = IDLE;
                end else begin
                    a_d   = {1'b0, a_q[3:1]};
                    b_d   = {1'b0, b_q[3:1]};
                    c_d   = c_nxt;
                    sum_d = {s_bit, sum_q[3:1]};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // sum_q[3:1] already holds s2..s0.
                        res_d   = {upper, bit4, s_bit, sum_q[3:1]};
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out  = res_q & {8{en}};
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  block enable; gates output and qualifies start.
REQ-005 start  input  1  one-cycle request to begin an addition.
REQ-006 a  input  4  first operand, sampled on accepted start.
REQ-007 b  input  4  second operand, sampled on accepted start.
REQ-008 out  output  8  result, forced to 0 whenever en=0.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when result becomes valid.

Function
REQ-011 FSM SHALL have states IDLE, RUN, DONE.
REQ-012 IDLE: start=1 and en=1 at a rising edge SHALL latch a, b into shift registers, clear carry, clear bit counter to 0, and go to RUN.
REQ-013 IDLE: start=1 with en=0 SHALL be ignored.
REQ-014 RUN: each edge SHALL compute one sum bit, LSB first (s_i = a_i ^ b_i ^ c; c <= majority), shift it into the result shift register, and increment the counter.
REQ-015 RUN: after the counter=3 bit is processed, FSM SHALL go to DONE and the 8-bit result register SHALL load {upper bits, bit4, s3..s0}.
REQ-016 Unsigned mode: bit4 = final carry, bits 7:5 = 0; result range 0..30.
REQ-017 Latency: start accepted at edge k; result register valid and done=1 during the cycle after edge k+4; FSM returns to IDLE at edge k+5.
REQ-018 DONE: done=1 for exactly one cycle; unconditional return to IDLE.
REQ-019 start during RUN or DONE SHALL be ignored (no restart, no queueing).
REQ-020 en dropped to 0 during RUN SHALL abort to IDLE at the next edge; result register keeps its previous value; no done pulse.
REQ-021 Result register SHALL hold its value in IDLE until the next completed addition.
REQ-022 out = result register AND {8{en}}, combinational on en.
REQ-023 busy = 1 exactly in RUN; done = 1 exactly in DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, result=0, out=0, busy=0, done=0, carry=0, counter=0.
REQ-025 Reset mid-operation SHALL discard the operation; no done pulse after release.
REQ-026 After rst_n release, first start SHALL be acceptable on the first clock edge.

Configuration
REQ-027 Macro ADD_SERIAL_SIGNED_EN SHALL select operand interpretation.
REQ-028 Defined: a, b are two's complement; bit4 = a3 ^ b3 ^ carry out of bit 3; bits 7:5 = copy of bit4 (sign-extended 5-bit sum, range -16..14).
REQ-029 Not defined: unsigned behaviour of REQ-016.
REQ-030 Latency, handshake and reset behaviour SHALL be identical in both builds.

Verification
REQ-031 en=1, a=3, b=4, start pulse -> busy for 4 cycles, done one cycle later, out=0x07.
REQ-032 Unsigned build, a=15, b=15 -> out=0x1E; signed build, same inputs -> out=0xFE; signed a=7, b=7 -> out=0x0E.
REQ-033 After result 0x07, drop en -> out=0x00 immediately; raise en -> out=0x07 again.
REQ-034 a=1, b=2 accepted, start again at cycle 2 with a=9, b=9 -> single done, out=0x03.
REQ-035 a=5, b=5 accepted, rst_n low during RUN -> out=0, busy=0, no done after release; then a=2, b=2 -> out=0x04.
REQ-036 Prior result 0x07, new start a=8, b=1, en low during RUN -> abort, no done, out=0x07 once en returns.
